// File: rtl/gen_audio_mix.sv
// Multi-channel sine mixer: CHANNELS phase-accumulator oscillators share one
// quarter-wave LUT and one multiplier; the sum is saturated to SAMPLE_W bits.
module gen_audio_mix #(
  parameter  int CHANNELS = 4,
  parameter  int SAMPLE_W = 16,
  parameter  int PHASE_W  = 24,
  parameter  int LUT_AW   = 8,
  parameter  int AMP_W    = 8,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                I_clk,
  input  logic                I_reset,
  input  logic                I_tick,
  input  logic                I_cfg_we,
  input  logic [CH_W-1:0]     I_cfg_ch,
  input  logic [PHASE_W-1:0]  I_cfg_inc,
  input  logic [AMP_W-1:0]    I_cfg_amp,
  input  logic                I_cfg_en,
  input  logic                I_ovr_clr,
  output logic [SAMPLE_W-1:0] O_sample,
  output logic                O_valid,
  output logic                O_busy,
  output logic                O_overrun
);

  localparam int  ACC_W = SAMPLE_W + $clog2(CHANNELS) + 1;
  localparam int  MUL_W = SAMPLE_W + AMP_W + 1;
  localparam int  LUT_N = 1 << LUT_AW;
  localparam int  SMAX  = (1 << (SAMPLE_W - 1)) - 1;
  localparam real PI    = 3.14159265358979323846;

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(SMAX);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-SMAX - 1);

  // Sample points sit at bin centres, so the quadrant mirror needs no +1 offset.
  function automatic int lut_entry(input int i);
    real x;
    x = real'(SMAX) * $sin(PI / 2.0 * (real'(i) + 0.5) / real'(LUT_N));
    return $rtoi(x + 0.5);
  endfunction

  logic signed [SAMPLE_W-1:0] lut [LUT_N];

  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    localparam int VAL = lut_entry(gi);
    assign lut[gi] = SAMPLE_W'(VAL);
  end

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_SCALE, S_ACC, S_OUT} state_t;

  state_t                     state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [SAMPLE_W-1:0] s_q, s_d;
  logic signed [SAMPLE_W-1:0] prod_q, prod_d;
  logic [PHASE_W-1:0]         phase_q [CHANNELS];
  logic [PHASE_W-1:0]         phase_d [CHANNELS];
  logic [PHASE_W-1:0]         sh_inc_q [CHANNELS];
  logic [PHASE_W-1:0]         sh_inc_d [CHANNELS];
  logic [AMP_W-1:0]           sh_amp_q [CHANNELS];
  logic [AMP_W-1:0]           sh_amp_d [CHANNELS];
  logic [CHANNELS-1:0]        sh_en_q, sh_en_d;
  logic [PHASE_W-1:0]         act_inc_q [CHANNELS];
  logic [PHASE_W-1:0]         act_inc_d [CHANNELS];
  logic [AMP_W-1:0]           act_amp_q [CHANNELS];
  logic [AMP_W-1:0]           act_amp_d [CHANNELS];
  logic [CHANNELS-1:0]        act_en_q, act_en_d;
  logic [CHANNELS-1:0]        pend_q, pend_d;
  logic [SAMPLE_W-1:0]        sample_q, sample_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       ovr_q, ovr_d;

  logic [PHASE_W-1:0]         cur_phase;
  logic [1:0]                 quad;
  logic [LUT_AW-1:0]          addr;
  logic signed [SAMPLE_W-1:0] lut_s;
  logic signed [MUL_W-1:0]    mul_a, mul_b, mul_p;
  logic                       cfg_hit;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    acc_d     = acc_q;
    s_d       = s_q;
    prod_d    = prod_q;
    phase_d   = phase_q;
    sh_inc_d  = sh_inc_q;
    sh_amp_d  = sh_amp_q;
    sh_en_d   = sh_en_q;
    act_inc_d = act_inc_q;
    act_amp_d = act_amp_q;
    act_en_d  = act_en_q;
    pend_d    = pend_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    ovr_d     = ovr_q;

    cur_phase = phase_q[ch_q];
    quad      = cur_phase[PHASE_W-1 -: 2];
    addr      = cur_phase[PHASE_W-3 -: LUT_AW];
    if (quad[0]) addr = ~addr;
    lut_s     = lut[addr];
    mul_a     = {{(MUL_W-SAMPLE_W){s_q[SAMPLE_W-1]}}, s_q};
    mul_b     = {{(MUL_W-AMP_W){1'b0}}, act_amp_q[ch_q]};
    mul_p     = mul_a * mul_b;
    cfg_hit   = I_cfg_we && (int'(I_cfg_ch) < CHANNELS);

    if (I_ovr_clr) ovr_d = 1'b0;
    if (I_tick && state_q != S_IDLE) ovr_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (I_tick) begin
          act_inc_d = sh_inc_q;
          act_amp_d = sh_amp_q;
          act_en_d  = sh_en_q;
          for (int c = 0; c < CHANNELS; c++) begin
            if (pend_q[c]) phase_d[c] = '0;
          end
          pend_d  = '0;
          acc_d   = '0;
          ch_d    = '0;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        s_d     = quad[1] ? -lut_s : lut_s;
        state_d = S_SCALE;
      end
      S_SCALE: begin
        prod_d  = SAMPLE_W'(mul_p >>> AMP_W);
        state_d = S_ACC;
      end
      S_ACC: begin
        if (act_en_q[ch_q]) begin
          acc_d         = acc_q + {{(ACC_W-SAMPLE_W){prod_q[SAMPLE_W-1]}}, prod_q};
          phase_d[ch_q] = phase_q[ch_q] + act_inc_q[ch_q];
        end
        if (ch_q == CH_W'(CHANNELS - 1)) begin
          state_d = S_OUT;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_OUT: begin
        if (acc_q > ACC_MAX)      sample_d = SAMPLE_W'(ACC_MAX);
        else if (acc_q < ACC_MIN) sample_d = SAMPLE_W'(ACC_MIN);
        else                      sample_d = SAMPLE_W'(acc_q);
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Applied after the tick handling so a write on the tick edge stays pending.
    if (cfg_hit) begin
      sh_inc_d[I_cfg_ch] = I_cfg_inc;
      sh_amp_d[I_cfg_ch] = I_cfg_amp;
      sh_en_d[I_cfg_ch]  = I_cfg_en;
      pend_d[I_cfg_ch]   = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      acc_q     <= '0;
      s_q       <= '0;
      prod_q    <= '0;
      phase_q   <= '{default: '0};
      sh_inc_q  <= '{default: '0};
      sh_amp_q  <= '{default: '0};
      sh_en_q   <= '0;
      act_inc_q <= '{default: '0};
      act_amp_q <= '{default: '0};
      act_en_q  <= '0;
      pend_q    <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      acc_q     <= acc_d;
      s_q       <= s_d;
      prod_q    <= prod_d;
      phase_q   <= phase_d;
      sh_inc_q  <= sh_inc_d;
      sh_amp_q  <= sh_amp_d;
      sh_en_q   <= sh_en_d;
      act_inc_q <= act_inc_d;
      act_amp_q <= act_amp_d;
      act_en_q  <= act_en_d;
      pend_q    <= pend_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
    end
  end

  assign O_sample  = sample_q;
  assign O_valid   = valid_q;
  assign O_busy    = busy_q;
  assign O_overrun = ovr_q;

endmodule

// File: tb/tb_gen_audio_mix.sv
// Scoreboard bench for gen_audio_mix: stimulus pushes expected samples and
// due cycles, a negedge monitor pops and compares on every O_valid.
module tb_gen_audio_mix;

  localparam int CHANNELS = 4;
  localparam int SAMPLE_W = 16;
  localparam int PHASE_W  = 24;
  localparam int LUT_AW   = 8;
  localparam int AMP_W    = 8;
  localparam int CH_W     = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                tick = 1'b0;
  logic                cfg_we = 1'b0;
  logic [CH_W-1:0]     cfg_ch = '0;
  logic [PHASE_W-1:0]  cfg_inc = '0;
  logic [AMP_W-1:0]    cfg_amp = '0;
  logic                cfg_en = 1'b0;
  logic                ovr_clr = 1'b0;
  logic [SAMPLE_W-1:0] o_sample;
  logic                o_valid;
  logic                o_busy;
  logic                o_overrun;

  gen_audio_mix #(
    .CHANNELS(CHANNELS), .SAMPLE_W(SAMPLE_W), .PHASE_W(PHASE_W),
    .LUT_AW(LUT_AW), .AMP_W(AMP_W)
  ) dut (
    .I_clk(clk), .I_reset(rst), .I_tick(tick), .I_cfg_we(cfg_we),
    .I_cfg_ch(cfg_ch), .I_cfg_inc(cfg_inc), .I_cfg_amp(cfg_amp),
    .I_cfg_en(cfg_en), .I_ovr_clr(ovr_clr), .O_sample(o_sample),
    .O_valid(o_valid), .O_busy(o_busy), .O_overrun(o_overrun)
  );

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (o_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got O_valid with sample %0d, required no pulse (cycle %0d)",
                 $signed(o_sample), cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("sample %0d at cycle %0d (expected %0d due %0d)", $signed(o_sample), cyc, e.val, e.due);
        check("sample", int'($signed(o_sample)), e.val);
        check("latency", cyc, e.due);
      end
    end
  end

  task automatic cfg(input logic [CH_W-1:0] ch, input logic [PHASE_W-1:0] inc,
                     input logic [AMP_W-1:0] amp, input logic en);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = ch; cfg_inc = inc; cfg_amp = amp; cfg_en = en;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic push_tick(input int exp);
    exp_t e;
    e.val = exp;
    e.due = cyc + 14;
    sb.push_back(e);
    tick = 1'b1;
  endtask

  // Runs one full sequence; busy is sampled on the 18 negedges after the tick.
  task automatic do_tick(input int exp, input bit chk_busy);
    int nb;
    nb = 0;
    @(negedge clk);
    push_tick(exp);
    @(negedge clk);
    tick = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (o_busy) nb++;
      @(negedge clk);
    end
    if (chk_busy) check("busy_cycles", nb, 13);
  endtask

  initial begin
    // 1: reset state and idle ticks
    repeat (3) @(negedge clk);
    #1;
    check("rst_sample", int'(o_sample), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_overrun", int'(o_overrun), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) do_tick(0, 1'b1);
    check("idle_overrun", int'(o_overrun), 0);

    // 2: single channel quarter-period tone
    cfg(2'd0, 24'h400000, 8'd255, 1'b1);
    for (int r = 0; r < 2; r++) begin
      do_tick(100, 1'b0);
      do_tick(32639, 1'b0);
      do_tick(-101, 1'b0);
      do_tick(-32640, 1'b0);
    end

    // 3: four identical channels, saturating peaks
    for (int c = 1; c < 4; c++) cfg(CH_W'(c), 24'h400000, 8'd255, 1'b1);
    do_tick(400, 1'b0);
    do_tick(32767, 1'b0);
    do_tick(-404, 1'b0);
    do_tick(-32768, 1'b0);

    // 4: overrun from a tick 5 edges into a sequence
    @(negedge clk);
    push_tick(400);
    @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("ovr_set", int'(o_overrun), 1);
    repeat (14) @(negedge clk);
    check("ovr_hold", int'(o_overrun), 1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_clr", int'(o_overrun), 0);
    @(negedge clk);
    push_tick(32767);
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    tick = 1'b1;
    ovr_clr = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    ovr_clr = 1'b0;
    check("ovr_set_wins", int'(o_overrun), 1);
    repeat (16) @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_clr2", int'(o_overrun), 0);

    // 5: mid-sequence write affects only the next sample
    for (int c = 1; c < 4; c++) cfg(CH_W'(c), 24'h400000, 8'd255, 1'b0);
    @(negedge clk);
    push_tick(-101);
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    cfg(2'd0, 24'h400000, 8'd128, 1'b1);
    repeat (16) @(negedge clk);
    do_tick(50, 1'b1);
    do_tick(16383, 1'b0);

    // 6: async reset mid-sequence aborts and clears config
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("ovr_before_rst", int'(o_overrun), 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_sample", int'(o_sample), 0);
    check("arst_valid", int'(o_valid), 0);
    check("arst_busy", int'(o_busy), 0);
    check("arst_overrun", int'(o_overrun), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    do_tick(0, 1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
